// File: rtl/df_mon_pkg.sv
// Shared types for the dataflow performance monitor: per-process FSM states,
// read-field codes and the outstanding-counter width.
package df_mon_pkg;

  localparam int OUTST_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACTIVE    = 2'd1,
    ST_IN_STALL  = 2'd2,
    ST_OUT_STALL = 2'd3
  } proc_state_e;

  localparam logic [2:0] FLD_STARTS    = 3'd0;
  localparam logic [2:0] FLD_DONES     = 3'd1;
  localparam logic [2:0] FLD_ACTIVE    = 3'd2;
  localparam logic [2:0] FLD_IN_STALL  = 3'd3;
  localparam logic [2:0] FLD_OUT_STALL = 3'd4;
  localparam logic [2:0] FLD_OUTST     = 3'd5;
  localparam logic [2:0] FLD_STATE     = 3'd6;
  localparam logic [2:0] FLD_ZERO      = 3'd7;

endpackage

// File: rtl/df_proc_counters.sv
// One monitored process: handshake counting, outstanding tracking, activity FSM
// and saturating cycle counters. clear zeroes counters only; FSM/outstanding stay live.
module df_proc_counters
  import df_mon_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_ap_start,
  input  logic               i_ap_ready,
  input  logic               i_ap_done,
  input  logic               i_ap_continue,
  input  logic               i_cin_stall,
  input  logic               i_cout_stall,
  output logic [CNT_W-1:0]   o_starts,
  output logic [CNT_W-1:0]   o_dones,
  output logic [CNT_W-1:0]   o_active,
  output logic [CNT_W-1:0]   o_in_stall,
  output logic [CNT_W-1:0]   o_out_stall,
  output logic [OUTST_W-1:0] o_outst,
  output proc_state_e        o_state,
  output logic               o_idle,
  output logic               o_stalled
);

  logic               w_start;
  logic               w_done;
  logic               w_idle;
  proc_state_e        r_state;
  proc_state_e        w_state_nxt;
  logic [OUTST_W-1:0] r_outst;
  logic [CNT_W-1:0]   r_starts;
  logic [CNT_W-1:0]   r_dones;
  logic [CNT_W-1:0]   r_active;
  logic [CNT_W-1:0]   r_in_stall;
  logic [CNT_W-1:0]   r_out_stall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  assign w_start = i_ap_start & i_ap_ready;
  assign w_done  = i_ap_done & i_ap_continue;
  assign w_idle  = (r_outst == '0) & ~i_ap_start;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Input starvation wins over output backpressure when both are present.
  always_comb begin
    w_state_nxt = ST_ACTIVE;
    if (w_idle)            w_state_nxt = ST_IDLE;
    else if (i_cin_stall)  w_state_nxt = ST_IN_STALL;
    else if (i_cout_stall) w_state_nxt = ST_OUT_STALL;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_outst <= '0;
    end else if (w_start && !w_done && (r_outst != '1)) begin
      r_outst <= r_outst + OUTST_W'(1);
    end else if (w_done && !w_start && (r_outst != '0)) begin
      r_outst <= r_outst - OUTST_W'(1);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_starts    <= '0;
      r_dones     <= '0;
      r_active    <= '0;
      r_in_stall  <= '0;
      r_out_stall <= '0;
    end else if (i_clear) begin
      r_starts    <= '0;
      r_dones     <= '0;
      r_active    <= '0;
      r_in_stall  <= '0;
      r_out_stall <= '0;
    end else begin
      r_starts    <= sat_inc(r_starts, w_start);
      r_dones     <= sat_inc(r_dones, w_done);
      r_active    <= sat_inc(r_active, r_state == ST_ACTIVE);
      r_in_stall  <= sat_inc(r_in_stall, r_state == ST_IN_STALL);
      r_out_stall <= sat_inc(r_out_stall, r_state == ST_OUT_STALL);
    end
  end

  assign o_starts    = r_starts;
  assign o_dones     = r_dones;
  assign o_active    = r_active;
  assign o_in_stall  = r_in_stall;
  assign o_out_stall = r_out_stall;
  assign o_outst     = r_outst;
  assign o_state     = r_state;
  assign o_idle      = w_idle;
  assign o_stalled   = (r_state == ST_IN_STALL) || (r_state == ST_OUT_STALL);

endmodule

// File: rtl/df_perf_monitor.sv
// Dataflow performance monitor: per-process counters, all-stalled watchdog with sticky
// deadlock flag/mask, and a registered one-cycle counter read port.
module df_perf_monitor
  import df_mon_pkg::*;
#(
  parameter  int NUM_PROC   = 4,
  parameter  int CNT_W      = 32,
  parameter  int WDOG_LIMIT = 1024,
  localparam int SEL_W      = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic [NUM_PROC-1:0] ap_start,
  input  logic [NUM_PROC-1:0] ap_ready,
  input  logic [NUM_PROC-1:0] ap_done,
  input  logic [NUM_PROC-1:0] ap_continue,
  input  logic [NUM_PROC-1:0] cin_stall,
  input  logic [NUM_PROC-1:0] cout_stall,
  input  logic                rd_req,
  input  logic [SEL_W-1:0]    rd_sel,
  input  logic [2:0]          rd_field,
  output logic                rd_valid,
  output logic [CNT_W-1:0]    rd_data,
  output logic [NUM_PROC-1:0] proc_idle,
  output logic                deadlock,
  output logic [NUM_PROC-1:0] deadlock_mask
);

  localparam int             WD_W    = $clog2(WDOG_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_LIMIT - 1);

  logic [CNT_W-1:0]   w_starts    [NUM_PROC];
  logic [CNT_W-1:0]   w_dones     [NUM_PROC];
  logic [CNT_W-1:0]   w_active    [NUM_PROC];
  logic [CNT_W-1:0]   w_in_stall  [NUM_PROC];
  logic [CNT_W-1:0]   w_out_stall [NUM_PROC];
  logic [OUTST_W-1:0] w_outst     [NUM_PROC];
  proc_state_e        w_state     [NUM_PROC];
  logic [NUM_PROC-1:0] w_stalled;
  logic [NUM_PROC-1:0] w_nonidle;
  logic                w_all_stalled;
  logic [CNT_W-1:0]    w_rd_mux;

  logic [WD_W-1:0]     r_wdog;
  logic                r_deadlock;
  logic [NUM_PROC-1:0] r_mask;
  logic                r_rd_valid;
  logic [CNT_W-1:0]    r_rd_data;

  for (genvar g = 0; g < NUM_PROC; g++) begin : g_proc
    df_proc_counters #(.CNT_W(CNT_W)) u_proc (
      .i_clock       (clock),
      .i_reset       (reset),
      .i_clear       (clear),
      .i_ap_start    (ap_start[g]),
      .i_ap_ready    (ap_ready[g]),
      .i_ap_done     (ap_done[g]),
      .i_ap_continue (ap_continue[g]),
      .i_cin_stall   (cin_stall[g]),
      .i_cout_stall  (cout_stall[g]),
      .o_starts      (w_starts[g]),
      .o_dones       (w_dones[g]),
      .o_active      (w_active[g]),
      .o_in_stall    (w_in_stall[g]),
      .o_out_stall   (w_out_stall[g]),
      .o_outst       (w_outst[g]),
      .o_state       (w_state[g]),
      .o_idle        (proc_idle[g]),
      .o_stalled     (w_stalled[g])
    );
    assign w_nonidle[g] = (w_state[g] != ST_IDLE);
  end

  // Deadlock candidate: someone is busy and no busy process is making progress.
  assign w_all_stalled = (|w_nonidle) && ((w_nonidle & ~w_stalled) == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wdog     <= '0;
      r_deadlock <= 1'b0;
      r_mask     <= '0;
    end else if (clear) begin
      r_wdog     <= '0;
      r_deadlock <= 1'b0;
      r_mask     <= '0;
    end else if (!r_deadlock) begin
      if (w_all_stalled) begin
        r_wdog <= r_wdog + WD_W'(1);
        if (r_wdog == WD_LAST) begin
          r_deadlock <= 1'b1;
          r_mask     <= w_stalled;
        end
      end else begin
        r_wdog <= '0;
      end
    end
  end

  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < NUM_PROC; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        case (rd_field)
          FLD_STARTS:    w_rd_mux = w_starts[i];
          FLD_DONES:     w_rd_mux = w_dones[i];
          FLD_ACTIVE:    w_rd_mux = w_active[i];
          FLD_IN_STALL:  w_rd_mux = w_in_stall[i];
          FLD_OUT_STALL: w_rd_mux = w_out_stall[i];
          FLD_OUTST:     w_rd_mux = CNT_W'(w_outst[i]);
          FLD_STATE:     w_rd_mux = CNT_W'(w_state[i]);
          FLD_ZERO:      w_rd_mux = '0;
          default:       w_rd_mux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= rd_req;
      if (rd_req) r_rd_data <= w_rd_mux;
    end
  end

  assign rd_valid      = r_rd_valid;
  assign rd_data       = r_rd_data;
  assign deadlock      = r_deadlock;
  assign deadlock_mask = r_mask;

endmodule

// File: tb/tb_df_perf_monitor.sv
// Randomized + directed bench for df_perf_monitor against a behavioural model.
module tb_df_perf_monitor;

  localparam int NP   = 4;
  localparam int CW   = 4;
  localparam int WL   = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock;
  logic          reset;
  logic          clear;
  logic [NP-1:0] ap_start, ap_ready, ap_done, ap_continue, cin_stall, cout_stall;
  logic          rd_req;
  logic [1:0]    rd_sel;
  logic [2:0]    rd_field;
  logic          rd_valid;
  logic [CW-1:0] rd_data;
  logic [NP-1:0] proc_idle;
  logic          deadlock;
  logic [NP-1:0] deadlock_mask;

  df_perf_monitor #(.NUM_PROC(NP), .CNT_W(CW), .WDOG_LIMIT(WL)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .cin_stall(cin_stall), .cout_stall(cout_stall),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_field(rd_field),
    .rd_valid(rd_valid), .rd_data(rd_data), .proc_idle(proc_idle),
    .deadlock(deadlock), .deadlock_mask(deadlock_mask)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: state codes 0 idle, 1 active, 2 in-stall, 3 out-stall;
  // m_cnt fields 0 starts, 1 dones, 2 active, 3 in-stall, 4 out-stall.
  int            m_outst [NP];
  int            m_state [NP];
  int            m_cnt   [NP][5];
  int            m_run;
  bit            m_dl;
  logic [NP-1:0] m_mask;
  bit            m_rdv;
  int            m_rdd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_outst[p] = 0;
      m_state[p] = 0;
      for (int f = 0; f < 5; f++) m_cnt[p][f] = 0;
    end
    m_run = 0; m_dl = 0; m_mask = '0; m_rdv = 0; m_rdd = 0;
  endtask

  function automatic int model_field(input int p, input int f);
    if (p >= NP) return 0;
    if (f < 5)   return m_cnt[p][f];
    if (f == 5)  return m_outst[p] & CMAX;
    if (f == 6)  return m_state[p];
    return 0;
  endfunction

  function automatic logic [NP-1:0] model_idle();
    logic [NP-1:0] v;
    for (int p = 0; p < NP; p++) v[p] = (m_outst[p] == 0) && !ap_start[p];
    return v;
  endfunction

  task automatic model_update();
    bit            any_busy, none_progress;
    logic [NP-1:0] stv;
    if (reset) begin
      model_reset();
      return;
    end
    m_rdv = rd_req;
    if (rd_req) m_rdd = model_field(int'(rd_sel), int'(rd_field));
    any_busy = 0; none_progress = 1; stv = '0;
    for (int p = 0; p < NP; p++) begin
      if (m_state[p] == 1) begin any_busy = 1; none_progress = 0; end
      else if (m_state[p] >= 2) begin any_busy = 1; stv[p] = 1'b1; end
    end
    if (clear) begin
      m_run = 0; m_dl = 0; m_mask = '0;
    end else if (!m_dl) begin
      if (any_busy && none_progress) begin
        m_run++;
        if (m_run == WL) begin m_dl = 1; m_mask = stv; end
      end else begin
        m_run = 0;
      end
    end
    for (int p = 0; p < NP; p++) begin
      bit s, d;
      int nst;
      s = ap_start[p] & ap_ready[p];
      d = ap_done[p] & ap_continue[p];
      if (m_outst[p] == 0 && !ap_start[p]) nst = 0;
      else if (cin_stall[p])               nst = 2;
      else if (cout_stall[p])              nst = 3;
      else                                 nst = 1;
      if (clear) begin
        for (int f = 0; f < 5; f++) m_cnt[p][f] = 0;
      end else begin
        m_cnt[p][0] = sat(m_cnt[p][0] + int'(s), CMAX);
        m_cnt[p][1] = sat(m_cnt[p][1] + int'(d), CMAX);
        if (m_state[p] != 0) m_cnt[p][m_state[p] + 1] = sat(m_cnt[p][m_state[p] + 1] + 1, CMAX);
      end
      if (s && !d)      m_outst[p] = sat(m_outst[p] + 1, 255);
      else if (d && !s) m_outst[p] = (m_outst[p] > 0) ? m_outst[p] - 1 : 0;
      m_state[p] = nst;
    end
  endtask

  // One clock: compare every output at the falling edge, then advance the model.
  task automatic step();
    @(negedge clock);
    chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
    if (m_rdv) chk("rd_data", 32'(rd_data), 32'(m_rdd));
    chk("proc_idle", 32'(proc_idle), 32'(model_idle()));
    chk("deadlock", 32'(deadlock), 32'(m_dl));
    chk("deadlock_mask", 32'(deadlock_mask), 32'(m_mask));
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic zero_inputs();
    clear = 0; ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '0;
    cin_stall = '0; cout_stall = '0; rd_req = 0; rd_sel = '0; rd_field = '0;
  endtask

  task automatic read_chk(input int sel, input int fld, input int exp, input string name);
    rd_req = 1; rd_sel = 2'(sel); rd_field = 3'(fld);
    step();
    rd_req = 0;
    chk({name, "_valid"}, 32'(rd_valid), 32'd1);
    chk(name, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    zero_inputs();
    reset = 1;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_deadlock", 32'(deadlock), 32'd0);
    chk("rst_mask", 32'(deadlock_mask), 32'd0);
    chk("rst_idle", 32'(proc_idle), 32'hF);
    reset = 0;
    step();

    // Process 0: three starts then three dones.
    ap_ready[0] = 1;
    ap_start[0] = 1;
    repeat (3) step();
    ap_start[0] = 0; ap_done[0] = 1; ap_continue[0] = 1;
    repeat (3) step();
    ap_done[0] = 0; ap_continue[0] = 0;
    chk("p0_idle_after_done", 32'(proc_idle[0]), 32'd1);
    read_chk(0, 0, 3, "p0_starts");
    read_chk(0, 1, 3, "p0_dones");
    read_chk(0, 5, 0, "p0_outst");

    // Process 1: both stalls high for 10 cycles while busy.
    clear = 1; step(); clear = 0;
    ap_ready[1] = 1; ap_start[1] = 1; step(); ap_start[1] = 0;
    cin_stall[1] = 1; cout_stall[1] = 1;
    repeat (10) step();
    cin_stall[1] = 0; cout_stall[1] = 0;
    step();
    read_chk(1, 3, 10, "p1_in_stall");
    read_chk(1, 4, 0, "p1_out_stall");
    ap_done[1] = 1; ap_continue[1] = 1; step(); ap_done[1] = 0; ap_continue[1] = 0;
    step();

    // Processes 0 and 2 busy and stalled until the watchdog fires.
    zero_inputs();
    clear = 1; step(); clear = 0;
    ap_ready = 4'b0101; ap_start = 4'b0101; step(); ap_start = '0;
    cin_stall[0] = 1; cout_stall[2] = 1;
    n = 0;
    while (!deadlock && n < 40) begin step(); n++; end
    chk("dl_rise_cycle", 32'(n), 32'd17);
    chk("dl_mask", 32'(deadlock_mask), 32'b0101);
    repeat (3) step();
    chk("dl_sticky", 32'(deadlock), 32'd1);
    clear = 1; cin_stall = '0; cout_stall = '0; step(); clear = 0;
    chk("dl_cleared", 32'(deadlock), 32'd0);
    chk("dl_mask_cleared", 32'(deadlock_mask), 32'd0);
    ap_done = 4'b0101; ap_continue = 4'b0101; step(); ap_done = '0; ap_continue = '0;
    step();

    // Process 3: simultaneous start and done with two outstanding.
    zero_inputs();
    clear = 1; step(); clear = 0;
    ap_ready[3] = 1; ap_start[3] = 1; repeat (2) step();
    ap_done[3] = 1; ap_continue[3] = 1; step();
    ap_start[3] = 0; ap_done[3] = 0; ap_continue[3] = 0;
    read_chk(3, 5, 2, "p3_outst");
    read_chk(3, 0, 3, "p3_starts");
    read_chk(3, 1, 1, "p3_dones");
    ap_done[3] = 1; ap_continue[3] = 1; repeat (2) step();
    ap_done[3] = 0; ap_continue[3] = 0;
    step();

    // Start counter saturation at the 4-bit limit.
    zero_inputs();
    clear = 1; step(); clear = 0;
    ap_ready[0] = 1; ap_start[0] = 1; repeat (20) step(); ap_start[0] = 0;
    read_chk(0, 0, 15, "p0_starts_sat");
    ap_done[0] = 1; ap_continue[0] = 1; repeat (20) step();
    zero_inputs();
    read_chk(0, 7, 0, "field7_zero");
    step();

    // Randomized traffic; every third segment forces all-stall pressure.
    for (int seg = 0; seg < 30; seg++) begin
      for (int c = 0; c < 60; c++) begin
        if (seg % 3 == 1) begin
          ap_start   = 4'($urandom & $urandom & $urandom);
          ap_done    = 4'($urandom & $urandom & $urandom);
          cin_stall  = 4'($urandom);
          cout_stall = ~cin_stall | 4'($urandom);
        end else begin
          ap_start   = 4'($urandom);
          ap_done    = 4'($urandom);
          cin_stall  = 4'($urandom & $urandom);
          cout_stall = 4'($urandom & $urandom);
        end
        ap_ready    = 4'($urandom);
        ap_continue = 4'($urandom);
        rd_req      = 1'($urandom);
        rd_sel      = 2'($urandom);
        rd_field    = 3'($urandom);
        clear       = ($urandom_range(0, 63) == 0);
        step();
      end
    end

    // Reset pulsed during a pending read with counters non-zero.
    zero_inputs();
    clear = 1; step(); clear = 0;
    ap_ready[1] = 1; ap_start[1] = 1; repeat (3) step(); ap_start[1] = 0;
    step();
    rd_req = 1; rd_sel = 2'd1; rd_field = 3'd0;
    step();
    reset = 1;
    model_reset();
    #1;
    chk("rst_mid_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_mid_rd_data", 32'(rd_data), 32'd0);
    step();
    reset = 0; rd_req = 0;
    step();
    chk("rst_after_rd_valid", 32'(rd_valid), 32'd0);
    zero_inputs();
    for (int p = 0; p < NP; p++)
      for (int f = 0; f < 8; f++)
        read_chk(p, f, 0, "post_rst_field");
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/df_perf_monitor.md
DF_PERF_MONITOR -- requirements
Module: df_perf_monitor

Interface
REQ-001 SHALL have parameter NUM_PROC, default 4, number of monitored dataflow processes (1..16).
REQ-002 SHALL have parameter CNT_W, default 32, width of every event and cycle counter.
REQ-003 SHALL have parameter WDOG_LIMIT, default 1024, consecutive all-stalled cycles before deadlock is declared (>=2).
REQ-004 SHALL have ports in this order:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- clear  in  1  synchronous clear of all counters, the deadlock flag and the deadlock mask.
- ap_start, ap_ready, ap_done, ap_continue  in  NUM_PROC each  per-process handshake taps.
- cin_stall, cout_stall  in  NUM_PROC each  per-process input-FIFO-empty and output-FIFO-full stall taps.
- rd_req  in  1  counter read strobe.
- rd_sel  in  $clog2(NUM_PROC), min 1  process index.
- rd_field  in  3  counter select.
- rd_valid  out  1  read data valid.
- rd_data  out  CNT_W  read data.
- proc_idle  out  NUM_PROC  per-process idle.
- deadlock  out  1  sticky deadlock flag.
- deadlock_mask  out  NUM_PROC  processes that were stalled when deadlock was set.

Function
REQ-005 SHALL count a start for process i on each cycle with ap_start[i]&ap_ready[i], and a done on each cycle with ap_done[i]&ap_continue[i].
REQ-006 SHALL keep a per-process outstanding counter, 8 bits wide, updated as +start -done, net 0 when both occur in the same cycle; it SHALL saturate at 255 and SHALL NOT decrement below 0.
REQ-007 SHALL compute proc_idle[i] = (outstanding==0) & ~ap_start[i], combinationally from registered state and the current input.
REQ-008 SHALL run a per-process FSM with states IDLE, ACTIVE, IN_STALL and OUT_STALL. The next state is evaluated every cycle:
- proc_idle -> IDLE;
- else cin_stall -> IN_STALL;
- else cout_stall -> OUT_STALL;
- else ACTIVE.
- cin_stall takes priority when cin_stall and cout_stall are both high.
REQ-009 SHALL keep per-process counters, selected by rd_field:
- 0 starts
- 1 dones
- 2 active cycles
- 3 in-stall cycles
- 4 out-stall cycles
- 5 {zero-padded outstanding}
- 6 {zero-padded FSM state code: IDLE=0, ACTIVE=1, IN_STALL=2, OUT_STALL=3}
- 7 reads 0.
REQ-010 Cycle counters SHALL increment once per cycle spent in the registered state they name; all CNT_W counters SHALL saturate at all-ones and never wrap.
REQ-011 A read SHALL be 1-cycle latency: rd_req in cycle n gives rd_valid=1 and rd_data in cycle n+1. rd_valid SHALL be 0 otherwise. rd_sel>=NUM_PROC SHALL return 0 with rd_valid=1.
REQ-012 A read in the same cycle as an increment SHALL return the pre-increment value.
REQ-013 SHALL keep a watchdog counter that increments when at least one process is non-idle and every non-idle process is in IN_STALL or OUT_STALL, and otherwise resets to 0.
REQ-014 When the watchdog reaches WDOG_LIMIT-1 and increments, deadlock SHALL be set next cycle and deadlock_mask SHALL latch the stalled-process vector. Both SHALL hold until clear or reset, and the watchdog SHALL stop.
REQ-015 clear SHALL zero all counters, the watchdog, deadlock and deadlock_mask next cycle. It SHALL override same-cycle increments. It SHALL NOT alter the FSM state or outstanding (these track live handshakes).

Reset
REQ-016 Asserting reset SHALL immediately set, in every process: FSM state to IDLE, all counters to 0, outstanding to 0, watchdog to 0, rd_valid=0, rd_data=0, deadlock=0, deadlock_mask=0.
REQ-017 Reset asserted mid-operation SHALL discard any pending read; first valid sampling is the first rising edge after deassertion.

Structure
REQ-018 SHALL place the FSM state enum, the rd_field codes and OUTST_W=8 in shared package df_mon_pkg.
REQ-019 SHALL instantiate NUM_PROC copies of sub-module df_proc_counters (FSM, outstanding counter and the five counters for one process). The top SHALL hold the watchdog, deadlock logic and read mux.

Verification
REQ-020 Process 0: 3 start handshakes, then 3 done handshakes. Reading fields 0/1/5 SHALL return 3/3/0, and proc_idle[0]=1 after the last done.
REQ-021 Process 1 non-idle, cin_stall=1 and cout_stall=1 for 10 cycles. Field 3 SHALL read 10, field 4 SHALL read 0.
REQ-022 WDOG_LIMIT=16, processes 0 and 2 non-idle and stalled for 16 cycles. deadlock SHALL rise on cycle 17 with deadlock_mask=4'b0101; a later clear SHALL drop it.
REQ-023 CNT_W=4, 20 start handshakes. Field 0 SHALL read 15 and SHALL not wrap.
REQ-024 Start and done in the same cycle with outstanding=2. Outstanding SHALL stay 2, and field 0 and field 1 SHALL each increment by 1.
REQ-025 reset pulsed while rd_req is high and counters are non-zero. rd_valid SHALL be 0 and all fields SHALL read 0 afterwards.
